cpu_memory: RTL and testbench

- Memory-access stage of the moxie pipeline. It sits between execute and cpu_write.
- Non-memory instructions pass through to writeback with one cycle of registered latency.
- Loads and stores run a single Wishbone-classic data-bus transaction, and the stage stalls execute until that transaction completes, errors or times out.
- Data is big-endian; byte and halfword loads are zero-extended.

---
 rtl/cpu_memory.sv | 212 +++++++++++++++++++++
 tb/tb_cpu_memory.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_memory.sv
// Memory-access stage of the moxie pipeline: registers ALU results through to
// writeback and runs one Wishbone-classic data transaction per load/store.
module cpu_memory #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [1:0]  mem_op_i,
  input  logic [1:0]  mem_size_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] store_data_i,
  input  logic [3:0]  register_write_index_i,
  input  logic        register_write_enable_i,
  input  logic [31:0] result_i,
  output logic        stall_o,
  output logic [3:0]  register_write_index_o,
  output logic        register_write_enable_o,
  output logic [31:0] result_o,
  output logic [31:0] dmem_adr_o,
  output logic [31:0] dmem_dat_o,
  input  logic [31:0] dmem_dat_i,
  output logic        dmem_we_o,
  output logic [3:0]  dmem_sel_o,
  output logic        dmem_cyc_o,
  output logic        dmem_stb_o,
  input  logic        dmem_ack_i,
  input  logic        dmem_err_i,
  output logic        mem_fault_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_t;

  localparam logic [1:0] OP_LOAD   = 2'b01;
  localparam logic [1:0] OP_STORE  = 2'b10;
  localparam logic [1:0] SZ_BYTE   = 2'b00;
  localparam logic [1:0] SZ_HALF   = 2'b01;
  localparam logic [7:0] CNT_LAST  = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_next;

  logic [7:0]  r_cnt;
  logic [3:0]  r_idx_lat;
  logic        r_en_lat;
  logic        r_is_load;
  logic [1:0]  r_size_lat;
  logic [1:0]  r_a10_lat;

  logic [3:0]  r_wr_idx;
  logic        r_wr_en;
  logic [31:0] r_result;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic        r_we;
  logic [3:0]  r_sel;
  logic        r_cyc;
  logic        r_stb;
  logic        r_fault;

  logic        w_is_mem;
  logic        w_misaligned;
  logic        w_accept;
  logic        w_abort;
  logic [3:0]  w_sel;
  logic [31:0] w_wdata;
  logic [31:0] w_rdata;

  // Request decode for the instruction presented by execute.
  always_comb begin
    w_is_mem     = valid_i && ((mem_op_i == OP_LOAD) || (mem_op_i == OP_STORE));
    w_misaligned = 1'b0;
    w_sel        = 4'b1111;
    w_wdata      = store_data_i;
    case (mem_size_i)
      SZ_BYTE: begin
        w_sel   = 4'b1000 >> mem_addr_i[1:0];
        w_wdata = {4{store_data_i[7:0]}};
      end
      SZ_HALF: begin
        w_misaligned = mem_addr_i[0];
        w_sel        = mem_addr_i[1] ? 4'b0011 : 4'b1100;
        w_wdata      = {2{store_data_i[15:0]}};
      end
      default: begin
        w_misaligned = (mem_addr_i[1:0] != 2'b00);
      end
    endcase
    w_accept = (r_state == IDLE) && w_is_mem && !w_misaligned;
    w_abort  = (r_state == BUS) && !dmem_ack_i && (dmem_err_i || (r_cnt == CNT_LAST));
  end

  // Big-endian lane extraction, zero-extended.
  always_comb begin
    w_rdata = dmem_dat_i;
    case (r_size_lat)
      SZ_BYTE: begin
        case (r_a10_lat)
          2'd0:    w_rdata = {24'h0, dmem_dat_i[31:24]};
          2'd1:    w_rdata = {24'h0, dmem_dat_i[23:16]};
          2'd2:    w_rdata = {24'h0, dmem_dat_i[15:8]};
          default: w_rdata = {24'h0, dmem_dat_i[7:0]};
        endcase
      end
      SZ_HALF: begin
        w_rdata = r_a10_lat[1] ? {16'h0, dmem_dat_i[15:0]} : {16'h0, dmem_dat_i[31:16]};
      end
      default: w_rdata = dmem_dat_i;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    if (r_state == IDLE) begin
      if (w_accept) w_state_next = BUS;
    end else begin
      if (dmem_ack_i || w_abort) w_state_next = IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_cnt      <= '0;
      r_idx_lat  <= '0;
      r_en_lat   <= 1'b0;
      r_is_load  <= 1'b0;
      r_size_lat <= '0;
      r_a10_lat  <= '0;
      r_wr_idx   <= '0;
      r_wr_en    <= 1'b0;
      r_result   <= '0;
      r_adr      <= '0;
      r_dat      <= '0;
      r_we       <= 1'b0;
      r_sel      <= '0;
      r_cyc      <= 1'b0;
      r_stb      <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_fault <= 1'b0;
      if (r_state == IDLE) begin
        if (!valid_i) begin
          r_wr_en <= 1'b0;
        end else if (!w_is_mem) begin
          r_wr_idx <= register_write_index_i;
          r_wr_en  <= register_write_enable_i;
          r_result <= result_i;
        end else if (w_misaligned) begin
          r_wr_en <= 1'b0;
          r_fault <= 1'b1;
        end else begin
          r_idx_lat  <= register_write_index_i;
          r_en_lat   <= register_write_enable_i;
          r_is_load  <= (mem_op_i == OP_LOAD);
          r_size_lat <= mem_size_i;
          r_a10_lat  <= mem_addr_i[1:0];
          r_cyc      <= 1'b1;
          r_stb      <= 1'b1;
          r_adr      <= {mem_addr_i[31:2], 2'b00};
          r_we       <= (mem_op_i == OP_STORE);
          r_sel      <= w_sel;
          r_dat      <= w_wdata;
          r_cnt      <= '0;
          r_wr_en    <= 1'b0;
        end
      end else begin
        if (dmem_ack_i) begin
          r_cyc <= 1'b0;
          r_stb <= 1'b0;
          r_we  <= 1'b0;
          if (r_is_load) begin
            r_result <= w_rdata;
            r_wr_en  <= r_en_lat;
            r_wr_idx <= r_idx_lat;
          end else begin
            r_wr_en <= 1'b0;
          end
        end else if (w_abort) begin
          r_cyc   <= 1'b0;
          r_stb   <= 1'b0;
          r_we    <= 1'b0;
          r_fault <= 1'b1;
          r_wr_en <= 1'b0;
        end else begin
          r_cnt   <= r_cnt + 8'd1;
          r_wr_en <= 1'b0;
        end
      end
    end
  end

  assign stall_o                 = (r_state == BUS);
  assign register_write_index_o  = r_wr_idx;
  assign register_write_enable_o = r_wr_en;
  assign result_o                = r_result;
  assign dmem_adr_o              = r_adr;
  assign dmem_dat_o              = r_dat;
  assign dmem_we_o               = r_we;
  assign dmem_sel_o              = r_sel;
  assign dmem_cyc_o              = r_cyc;
  assign dmem_stb_o              = r_stb;
  assign mem_fault_o             = r_fault;

endmodule

// File: tb/tb_cpu_memory.sv
// Directed bench for cpu_memory: vector table for single-beat accesses plus
// hand sequences for wait states, timeout, ack/err precedence and reset.
module tb_cpu_memory;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [1:0]  mem_op_i;
  logic [1:0]  mem_size_i;
  logic [31:0] mem_addr_i;
  logic [31:0] store_data_i;
  logic [3:0]  register_write_index_i;
  logic        register_write_enable_i;
  logic [31:0] result_i;
  logic        stall_o;
  logic [3:0]  register_write_index_o;
  logic        register_write_enable_o;
  logic [31:0] result_o;
  logic [31:0] dmem_adr_o;
  logic [31:0] dmem_dat_o;
  logic [31:0] dmem_dat_i;
  logic        dmem_we_o;
  logic [3:0]  dmem_sel_o;
  logic        dmem_cyc_o;
  logic        dmem_stb_o;
  logic        dmem_ack_i;
  logic        dmem_err_i;
  logic        mem_fault_o;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  cpu_memory #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .mem_op_i(mem_op_i),
    .mem_size_i(mem_size_i), .mem_addr_i(mem_addr_i), .store_data_i(store_data_i),
    .register_write_index_i(register_write_index_i),
    .register_write_enable_i(register_write_enable_i), .result_i(result_i),
    .stall_o(stall_o), .register_write_index_o(register_write_index_o),
    .register_write_enable_o(register_write_enable_o), .result_o(result_o),
    .dmem_adr_o(dmem_adr_o), .dmem_dat_o(dmem_dat_o), .dmem_dat_i(dmem_dat_i),
    .dmem_we_o(dmem_we_o), .dmem_sel_o(dmem_sel_o), .dmem_cyc_o(dmem_cyc_o),
    .dmem_stb_o(dmem_stb_o), .dmem_ack_i(dmem_ack_i), .dmem_err_i(dmem_err_i),
    .mem_fault_o(mem_fault_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic        fault;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] res;
  } vec_t;

  vec_t vt[13];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [1:0] sz,
                       input logic [31:0] addr, input logic [31:0] sd,
                       input logic [3:0] idx, input logic en, input logic [31:0] res);
    valid_i = v; mem_op_i = op; mem_size_i = sz; mem_addr_i = addr;
    store_data_i = sd; register_write_index_i = idx;
    register_write_enable_i = en; result_i = res;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          op     size   addr          sdata         rdata        flt  adr           sel      dat           res
    vt[0]  = '{2'b01, 2'b00, 32'h0000_1000, 32'h0,        32'hAABBCCDD, 1'b0, 32'h0000_1000, 4'b1000, 32'h0,        32'h0000_00AA};
    vt[1]  = '{2'b01, 2'b00, 32'h0000_1001, 32'h0,        32'hAABBCCDD, 1'b0, 32'h0000_1000, 4'b0100, 32'h0,        32'h0000_00BB};
    vt[2]  = '{2'b01, 2'b00, 32'h0000_1003, 32'h0,        32'hAABBCCDD, 1'b0, 32'h0000_1000, 4'b0001, 32'h0,        32'h0000_00DD};
    vt[3]  = '{2'b01, 2'b01, 32'h0000_1000, 32'h0,        32'hAABBCCDD, 1'b0, 32'h0000_1000, 4'b1100, 32'h0,        32'h0000_AABB};
    vt[4]  = '{2'b01, 2'b01, 32'h0000_1002, 32'h0,        32'hAABBCCDD, 1'b0, 32'h0000_1000, 4'b0011, 32'h0,        32'h0000_CCDD};
    vt[5]  = '{2'b01, 2'b10, 32'h0000_1004, 32'h0,        32'hAABBCCDD, 1'b0, 32'h0000_1004, 4'b1111, 32'h0,        32'hAABBCCDD};
    vt[6]  = '{2'b01, 2'b11, 32'h0000_1008, 32'h0,        32'h01020304, 1'b0, 32'h0000_1008, 4'b1111, 32'h0,        32'h01020304};
    vt[7]  = '{2'b10, 2'b00, 32'h0000_2001, 32'h123456A5, 32'h0,        1'b0, 32'h0000_2000, 4'b0100, 32'hA5A5A5A5, 32'h0};
    vt[8]  = '{2'b10, 2'b10, 32'h0000_2000, 32'hDEADBEEF, 32'h0,        1'b0, 32'h0000_2000, 4'b1111, 32'hDEADBEEF, 32'h0};
    vt[9]  = '{2'b01, 2'b01, 32'h0000_3001, 32'h0,        32'h0,        1'b1, 32'h0,         4'b0,    32'h0,        32'h0};
    vt[10] = '{2'b10, 2'b10, 32'h0000_3002, 32'h0,        32'h0,        1'b1, 32'h0,         4'b0,    32'h0,        32'h0};
    vt[11] = '{2'b01, 2'b10, 32'h0000_3001, 32'h0,        32'h0,        1'b1, 32'h0,         4'b0,    32'h0,        32'h0};
    vt[12] = '{2'b01, 2'b01, 32'h0000_3002, 32'h0,        32'h11228344, 1'b0, 32'h0000_3000, 4'b0011, 32'h0,        32'h0000_8344};

    rst_i = 1'b0;
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
    dmem_dat_i = '0; dmem_ack_i = 1'b0; dmem_err_i = 1'b0;
    tick(); tick();
    chk("rst_wen", {31'h0, register_write_enable_o}, 32'h0);
    chk("rst_idx", {28'h0, register_write_index_o}, 32'h0);
    chk("rst_res", result_o, 32'h0);
    chk("rst_cyc_stb_we", {29'h0, dmem_cyc_o, dmem_stb_o, dmem_we_o}, 32'h0);
    chk("rst_adr", dmem_adr_o, 32'h0);
    chk("rst_sel", {28'h0, dmem_sel_o}, 32'h0);
    chk("rst_fault_stall", {30'h0, mem_fault_o, stall_o}, 32'h0);
    rst_i = 1'b1;

    // ALU passthrough, reserved op, bubble
    drive(1'b1, 2'b00, 2'b10, 32'h0, 32'h0, 4'd5, 1'b1, 32'h12345678);
    tick();
    chk("alu_idx", {28'h0, register_write_index_o}, 32'd5);
    chk("alu_wen", {31'h0, register_write_enable_o}, 32'd1);
    chk("alu_res", result_o, 32'h12345678);
    chk("alu_stall_cyc", {30'h0, stall_o, dmem_cyc_o}, 32'h0);
    drive(1'b1, 2'b11, 2'b10, 32'h0, 32'h0, 4'd9, 1'b1, 32'hCAFEF00D);
    tick();
    chk("rsv_idx_wen", {27'h0, register_write_index_o, register_write_enable_o}, {27'h0, 4'd9, 1'b1});
    chk("rsv_res", result_o, 32'hCAFEF00D);
    chk("rsv_stall_cyc", {30'h0, stall_o, dmem_cyc_o}, 32'h0);
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 4'd1, 1'b1, 32'h0);
    tick();
    chk("bubble_wen", {31'h0, register_write_enable_o}, 32'h0);

    // Table: single-beat accesses with ack in the first bus cycle
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, vt[i].op, vt[i].size, vt[i].addr, vt[i].sdata, 4'd3, 1'b1, 32'hFFFF_FFFF);
      tick();
      chk($sformatf("v%0d_wen_acc", i), {31'h0, register_write_enable_o}, 32'h0);
      if (vt[i].fault) begin
        chk($sformatf("v%0d_flt", i), {31'h0, mem_fault_o}, 32'h1);
        chk($sformatf("v%0d_nobus", i), {29'h0, dmem_cyc_o, dmem_stb_o, stall_o}, 32'h0);
        drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 4'd0, 1'b0, 32'h0);
        tick();
        chk($sformatf("v%0d_flt_end", i), {30'h0, mem_fault_o, stall_o}, 32'h0);
      end else begin
        chk($sformatf("v%0d_bus", i), {29'h0, dmem_cyc_o, dmem_stb_o, stall_o}, 32'h7);
        chk($sformatf("v%0d_adr", i), dmem_adr_o, vt[i].adr);
        chk($sformatf("v%0d_sel", i), {28'h0, dmem_sel_o}, {28'h0, vt[i].sel});
        chk($sformatf("v%0d_we", i), {31'h0, dmem_we_o}, {31'h0, vt[i].op == 2'b10});
        chk($sformatf("v%0d_flt0", i), {31'h0, mem_fault_o}, 32'h0);
        if (vt[i].op == 2'b10) chk($sformatf("v%0d_dat", i), dmem_dat_o, vt[i].dat);
        drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 4'd0, 1'b0, 32'h0);
        dmem_ack_i = 1'b1; dmem_dat_i = vt[i].rdata;
        tick();
        dmem_ack_i = 1'b0;
        chk($sformatf("v%0d_done", i), {28'h0, dmem_cyc_o, dmem_stb_o, dmem_we_o, stall_o}, 32'h0);
        if (vt[i].op == 2'b01) begin
          chk($sformatf("v%0d_res", i), result_o, vt[i].res);
          chk($sformatf("v%0d_wb", i), {27'h0, register_write_index_o, register_write_enable_o}, {27'h0, 4'd3, 1'b1});
        end else begin
          chk($sformatf("v%0d_st_wen", i), {31'h0, register_write_enable_o}, 32'h0);
        end
        tick();
        chk($sformatf("v%0d_wen_pulse", i), {31'h0, register_write_enable_o}, 32'h0);
      end
    end

    // Byte load with one wait state
    drive(1'b1, 2'b01, 2'b00, 32'h0000_1002, 32'h0, 4'd6, 1'b1, 32'h0);
    tick();
    chk("bl_adr", dmem_adr_o, 32'h0000_1000);
    chk("bl_sel", {28'h0, dmem_sel_o}, 32'h2);
    chk("bl_stall0", {31'h0, stall_o}, 32'h1);
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 4'd0, 1'b0, 32'h0);
    tick();
    chk("bl_stall1", {30'h0, stall_o, register_write_enable_o}, 32'h2);
    dmem_ack_i = 1'b1; dmem_dat_i = 32'hAABBCCDD;
    tick();
    dmem_ack_i = 1'b0;
    chk("bl_res", result_o, 32'h0000_00CC);
    chk("bl_wb", {26'h0, stall_o, register_write_index_o, register_write_enable_o}, {26'h0, 1'b0, 4'd6, 1'b1});
    tick();
    chk("bl_wen_off", {31'h0, register_write_enable_o}, 32'h0);

    // Half store, immediate ack
    drive(1'b1, 2'b10, 2'b01, 32'h0000_2002, 32'h0000BEEF, 4'd2, 1'b1, 32'h0);
    tick();
    chk("hs_bus", {27'h0, dmem_we_o, dmem_sel_o}, {27'h0, 1'b1, 4'b0011});
    chk("hs_dat", dmem_dat_o, 32'hBEEFBEEF);
    chk("hs_wen0", {31'h0, register_write_enable_o}, 32'h0);
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 4'd0, 1'b0, 32'h0);
    dmem_ack_i = 1'b1;
    tick();
    dmem_ack_i = 1'b0;
    chk("hs_wen1", {29'h0, register_write_enable_o, dmem_cyc_o, stall_o}, 32'h0);

    // Timeout with a follow-on ALU instruction held by execute
    drive(1'b1, 2'b01, 2'b10, 32'h0000_4000, 32'h0, 4'd4, 1'b1, 32'h0);
    tick();
    chk("to_stb0", {31'h0, dmem_stb_o}, 32'h1);
    drive(1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 4'd7, 1'b1, 32'h0000_0055);
    for (int c = 1; c < 4; c++) begin
      tick();
      chk($sformatf("to_stb%0d", c), {28'h0, dmem_stb_o, stall_o, mem_fault_o, register_write_enable_o}, 32'hC);
    end
    tick();
    chk("to_end", {28'h0, dmem_stb_o, stall_o, mem_fault_o, register_write_enable_o}, 32'h2);
    chk("to_cyc", {31'h0, dmem_cyc_o}, 32'h0);
    tick();
    chk("to_follow", {26'h0, mem_fault_o, register_write_index_o, register_write_enable_o}, {26'h0, 1'b0, 4'd7, 1'b1});
    chk("to_follow_res", result_o, 32'h0000_0055);

    // Ack and err together: ack wins; then err alone faults
    drive(1'b1, 2'b01, 2'b10, 32'h0000_5000, 32'h0, 4'd8, 1'b1, 32'h0);
    tick();
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 4'd0, 1'b0, 32'h0);
    dmem_ack_i = 1'b1; dmem_err_i = 1'b1; dmem_dat_i = 32'h600DF00D;
    tick();
    dmem_ack_i = 1'b0; dmem_err_i = 1'b0;
    chk("ae_res", result_o, 32'h600DF00D);
    chk("ae_flags", {29'h0, mem_fault_o, register_write_enable_o, stall_o}, 32'h2);
    drive(1'b1, 2'b01, 2'b10, 32'h0000_5004, 32'h0, 4'd8, 1'b1, 32'h0);
    tick();
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 4'd0, 1'b0, 32'h0);
    dmem_err_i = 1'b1;
    tick();
    dmem_err_i = 1'b0;
    chk("err_flags", {28'h0, dmem_cyc_o, mem_fault_o, register_write_enable_o, stall_o}, 32'h4);

    // Reset mid-transaction, then a late ack
    drive(1'b1, 2'b10, 2'b10, 32'h0000_6000, 32'h11111111, 4'd1, 1'b1, 32'h0);
    tick();
    chk("rb_stb", {31'h0, dmem_stb_o}, 32'h1);
    rst_i = 1'b0;
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 4'd0, 1'b0, 32'h0);
    tick();
    rst_i = 1'b1;
    chk("rb_ctl", {25'h0, dmem_cyc_o, dmem_stb_o, dmem_we_o, mem_fault_o, stall_o, register_write_enable_o, 1'b0}, 32'h0);
    chk("rb_res", result_o, 32'h0);
    chk("rb_adr", dmem_adr_o, 32'h0);
    chk("rb_dat", dmem_dat_o, 32'h0);
    chk("rb_sel_idx", {24'h0, dmem_sel_o, register_write_index_o}, 32'h0);
    dmem_ack_i = 1'b1; dmem_dat_i = 32'hFFFFFFFF;
    tick();
    dmem_ack_i = 1'b0;
    chk("late_ack", {28'h0, dmem_cyc_o, stall_o, mem_fault_o, register_write_enable_o}, 32'h0);
    chk("late_ack_res", result_o, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
